prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
Parametrised run controller for the next-generation processor core. It replaces the fixed single-program req/done behaviour with a multi-program entry table, an explicit start/halt handshake, a cycle counter and a watchdog timeout. It sits between the testbench/host handshake and the PC/datapath. It drives PC load, core enable and datapath clear, and observes the decoder's halt indication.

Parameters:
D, 12, program counter / instruction address width
NPROG, 4, number of program entry-table slots (power of two, >=2)
TW, 16, cycle-counter width
TIMEOUT, 16'hFFFF, watchdog limit in RUN cycles (must fit in TW bits)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req  input  1  start request; sampled in IDLE or DONE
prog_sel  input  $clog2(NPROG)  entry-table slot to run; captured with req
entry_we  input  1  write enable for entry table
entry_idx  input  $clog2(NPROG)  entry-table write slot
entry_addr  input  D  entry PC value to write
halt  input  1  decoder flags current instruction as halt
core_clr  output  1  one-cycle synchronous clear to register file/mapper
pc_load  output  1  PC loads pc_load_val this cycle
pc_load_val  output  D  entry address of selected program
run_en  output  1  core may advance PC and commit writes
busy  output  1  high in LOAD and RUN
done  output  1  high in DONE
timeout  output  1  sticky: last run ended by watchdog
cycles  output  TW  RUN cycles of current or last run, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0. Entry table cleared to 0. cycles=0. timeout=0.
- Entry table: written on a clk edge when entry_we=1, in any state. A write to the slot currently being loaded takes effect for the next req only; pc_load_val is taken from the captured value.
- States:
  - IDLE: req=1 -> capture prog_sel, latch table[prog_sel] into entry register -> LOAD.
  - LOAD (exactly 1 cycle): core_clr=1, pc_load=1, pc_load_val=entry register, run_en=0, cycles cleared to 0, timeout cleared -> RUN.
  - RUN: run_en=1; cycles increments each cycle, saturating at 2^TW-1.
    - halt=1 -> DONE. The halt instruction does not commit: run_en is forced 0 in that cycle, combinationally from halt.
    - Else if cycles reaches TIMEOUT-1 -> DONE with timeout=1.
    - If halt and timeout coincide, halt wins and timeout stays 0.
  - DONE: done=1, run_en=0, cycles frozen. req=1 -> capture and go to LOAD (restart without passing through IDLE). req=0 -> remain in DONE.
- req in LOAD/RUN is ignored (no queuing).
- Latency: req sampled high at edge N -> pc_load high during cycle N+1 -> first run_en cycle N+2.
- cycles counts RUN cycles including the halt cycle.
- Reset asserted mid-run aborts immediately to IDLE. There is no partial done.
- Outputs are registered from state, except run_en's halt masking.

Decomposition:
- Shared package (core_pkg): state enum typedef (IDLE, LOAD, RUN, DONE), default D/TW constants.
- One sub-module, seq_entry_table: NPROG x D register array with one write port and one async read port.
- FSM, counter and watchdog stay in prog_sequencer.

Test Plan:
1. Reset with table write slot 2 = 12'h040; req with prog_sel=2 -> pc_load=1 with pc_load_val=12'h040 one cycle later, core_clr=1 same cycle, run_en=1 the next cycle.
2. halt asserted on 10th RUN cycle -> run_en=0 that cycle, done=1 next cycle, cycles=10, timeout=0.
3. TIMEOUT=20, halt never asserted -> done=1 after 20 RUN cycles, timeout=1, cycles=20.
4. halt and watchdog limit in the same cycle -> done=1, timeout=0.
5. In DONE, req with prog_sel=1 (table=12'h100) -> LOAD directly, cycles and timeout cleared, pc_load_val=12'h100. req pulses during RUN have no effect.
6. Drive reset=0 asynchronously mid-RUN (between edges) -> busy, run_en and done go 0 immediately. After release, state is IDLE and table reads 0.

Source files
------------

// File: rtl/core_pkg.sv
// Types and default widths shared by the run-controller slice.
package core_pkg;
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } seq_state_t;

  localparam int unsigned D_DEF  = 12;
  localparam int unsigned TW_DEF = 16;
endpackage

// File: rtl/seq_entry_table.sv
// Program entry-address table: one write port and one async read port.
module seq_entry_table #(
  parameter int unsigned D     = 12,
  parameter int unsigned NPROG = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(NPROG)-1:0] i_wr_idx,
  input  logic [D-1:0]             i_wr_data,
  input  logic [$clog2(NPROG)-1:0] i_rd_idx,
  output logic [D-1:0]             o_rd_data
);
  logic [D-1:0] r_tbl [NPROG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NPROG); i++) begin
        r_tbl[i] <= '0;
      end
    end else if (i_we) begin
      r_tbl[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_tbl[i_rd_idx];
endmodule

// File: rtl/prog_sequencer.sv
// Run controller: entry-table start, start/halt handshake,
// RUN cycle counter and watchdog.
module prog_sequencer
  import core_pkg::*;
#(
  parameter int unsigned D       = D_DEF,
  parameter int unsigned NPROG   = 4,
  parameter int unsigned TW      = TW_DEF,
  parameter int unsigned TIMEOUT = 32'hFFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [$clog2(NPROG)-1:0] prog_sel,
  input  logic                     entry_we,
  input  logic [$clog2(NPROG)-1:0] entry_idx,
  input  logic [D-1:0]             entry_addr,
  input  logic                     halt,
  output logic                     core_clr,
  output logic                     pc_load,
  output logic [D-1:0]             pc_load_val,
  output logic                     run_en,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [TW-1:0]            cycles
);
  localparam logic [TW-1:0] LP_WD  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] LP_SAT = '1;

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [D-1:0]  r_entry;
  logic [D-1:0]  w_tbl_rd;
  logic [TW-1:0] r_cycles;
  logic          r_timeout;
  logic          w_start;
  logic          w_wd;

  seq_entry_table #(
    .D     (D),
    .NPROG (NPROG)
  ) u_tbl (
    .clk       (clk),
    .reset     (reset),
    .i_we      (entry_we),
    .i_wr_idx  (entry_idx),
    .i_wr_data (entry_addr),
    .i_rd_idx  (prog_sel),
    .o_rd_data (w_tbl_rd)
  );

  assign w_start = req & ((r_state == IDLE) | (r_state == DONE));
  // halt has priority over the watchdog
  assign w_wd    = (r_state == RUN) & ~halt & (r_cycles == LP_WD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (req) w_next = LOAD;
      LOAD:       w_next = RUN;
      RUN:        if (halt | (r_cycles == LP_WD)) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  // counters clear on the start edge so LOAD already shows a fresh run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_entry   <= '0;
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else if (w_start) begin
      r_entry   <= w_tbl_rd;
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == RUN) begin
      if (r_cycles != LP_SAT) r_cycles <= r_cycles + TW'(1);
      if (w_wd) r_timeout <= 1'b1;
    end
  end

  assign core_clr    = (r_state == LOAD);
  assign pc_load     = (r_state == LOAD);
  assign pc_load_val = (r_state == LOAD) ? r_entry : '0;
  assign run_en      = (r_state == RUN) & ~halt;
  assign busy        = (r_state == LOAD) | (r_state == RUN);
  assign done        = (r_state == DONE);
  assign timeout     = r_timeout;
  assign cycles      = r_cycles;
endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: loads and run ends are
// queued by the stimulus and checked by a negedge monitor.
module tb_prog_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [1:0]  prog_sel;
  logic        entry_we;
  logic [1:0]  entry_idx;
  logic [11:0] entry_addr;
  logic        halt;
  logic        core_clr;
  logic        pc_load;
  logic [11:0] pc_load_val;
  logic        run_en;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycles;

  typedef struct packed {
    logic [15:0] cyc;
    logic        to;
  } done_t;

  logic [11:0] q_load [$];
  done_t       q_done [$];
  logic [11:0] e_load;
  done_t       e_done;
  logic        done_q = 1'b0;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          waited;

  always #5 clk = ~clk;

  prog_sequencer #(
    .D       (12),
    .NPROG   (4),
    .TW      (16),
    .TIMEOUT (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .prog_sel    (prog_sel),
    .entry_we    (entry_we),
    .entry_idx   (entry_idx),
    .entry_addr  (entry_addr),
    .halt        (halt),
    .core_clr    (core_clr),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .run_en      (run_en),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycles      (cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (pc_load) begin
      if (q_load.size() == 0) begin
        chk("unexpected_load", {31'd0, pc_load}, 32'd0);
      end else begin
        e_load = q_load.pop_front();
        chk("load_val", {20'd0, pc_load_val}, {20'd0, e_load});
        chk("load_clr", {31'd0, core_clr}, 32'd1);
        chk("load_runen", {31'd0, run_en}, 32'd0);
      end
    end
    if (done && !done_q) begin
      if (q_done.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e_done = q_done.pop_front();
        chk("done_cycles", {16'd0, cycles}, {16'd0, e_done.cyc});
        chk("done_timeout", {31'd0, timeout}, {31'd0, e_done.to});
      end
    end
    done_q = done;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b0; req = 1'b0; prog_sel = '0; entry_we = 1'b0;
    entry_idx = '0; entry_addr = '0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_runen", {31'd0, run_en}, 0);
    chk("rst_pcload", {31'd0, pc_load}, 0);
    chk("rst_clr", {31'd0, core_clr}, 0);
    chk("rst_val", {20'd0, pc_load_val}, 0);
    chk("rst_cycles", {16'd0, cycles}, 0);
    chk("rst_timeout", {31'd0, timeout}, 0);
    reset = 1'b1;
    tick();
    entry_we = 1'b1; entry_idx = 2'd2; entry_addr = 12'h040;
    tick();
    entry_idx = 2'd1; entry_addr = 12'h100;
    tick();
    entry_we = 1'b0;

    // 1: start slot 2
    prog_sel = 2'd2; req = 1'b1; q_load.push_back(12'h040);
    tick();
    req = 1'b0;
    chk("t1_busy_load", {31'd0, busy}, 1);
    chk("t1_runen_load", {31'd0, run_en}, 0);
    tick();
    chk("t1_runen_run", {31'd0, run_en}, 1);
    chk("t1_pcload_off", {31'd0, pc_load}, 0);

    // 2: halt on RUN cycle 10
    repeat (9) tick();
    q_done.push_back('{cyc: 16'd10, to: 1'b0});
    halt = 1'b1;
    #1;
    chk("t2_halt_mask", {31'd0, run_en}, 0);
    tick();
    halt = 1'b0;
    chk("t2_done", {31'd0, done}, 1);
    chk("t2_runen_done", {31'd0, run_en}, 0);

    // 3: watchdog after 20 RUN cycles
    prog_sel = 2'd2; req = 1'b1; q_load.push_back(12'h040);
    q_done.push_back('{cyc: 16'd20, to: 1'b1});
    tick();
    req = 1'b0;
    chk("t3_cyc_clr", {16'd0, cycles}, 0);
    waited = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      waited++;
    end
    chk("t3_done_seen", {31'd0, done}, 1);
    chk("t3_latency", waited, 21);

    // 4: halt coincides with watchdog limit
    prog_sel = 2'd2; req = 1'b1; q_load.push_back(12'h040);
    tick();
    req = 1'b0;
    chk("t4_to_clr", {31'd0, timeout}, 0);
    chk("t4_cyc_clr", {16'd0, cycles}, 0);
    tick();
    repeat (19) tick();
    q_done.push_back('{cyc: 16'd20, to: 1'b0});
    halt = 1'b1;
    #1;
    chk("t4_halt_mask", {31'd0, run_en}, 0);
    tick();
    halt = 1'b0;
    chk("t4_done", {31'd0, done}, 1);
    chk("t4_timeout", {31'd0, timeout}, 0);

    // 5: restart from DONE on slot 1, req ignored during RUN
    prog_sel = 2'd1; req = 1'b1; q_load.push_back(12'h100);
    tick();
    req = 1'b0;
    chk("t5_cyc_clr", {16'd0, cycles}, 0);
    tick();
    prog_sel = 2'd2; req = 1'b1;
    repeat (3) tick();
    req = 1'b0;
    chk("t5_busy", {31'd0, busy}, 1);
    tick();
    q_done.push_back('{cyc: 16'd5, to: 1'b0});
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("t5_done", {31'd0, done}, 1);

    // 6: async reset mid-RUN
    prog_sel = 2'd1; req = 1'b1; q_load.push_back(12'h100);
    tick();
    req = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_runen", {31'd0, run_en}, 0);
    chk("t6_done", {31'd0, done}, 0);
    chk("t6_cycles", {16'd0, cycles}, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_idle_busy", {31'd0, busy}, 0);
    chk("t6_idle_done", {31'd0, done}, 0);
    prog_sel = 2'd2; req = 1'b1; q_load.push_back(12'h000);
    tick();
    req = 1'b0;
    tick();
    q_done.push_back('{cyc: 16'd1, to: 1'b0});
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("t6_done_after", {31'd0, done}, 1);

    tick();
    chk("q_load_empty", q_load.size(), 0);
    chk("q_done_empty", q_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
